pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage: holds the current fetch address and advances it by a fixed step when fetch accepts. It arbitrates exception and branch redirects, and captures a branch redirect that arrives during a stall so it is not lost. It replaces the single-register PC with a small FSM that adds boot delay, pending-redirect buffering and a fetch handshake. Sits between the hazard unit (stall enable), the branch/exception logic and the instruction memory port.

---
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen.sv | 128 ++++++++++++
 tb/tb_pc_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: redirect/stall/ack inputs and fetch address outputs.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic             br_valid;
    logic [WIDTH-1:0] br_target;
    logic             exc_valid;
    logic             fetch_ack;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             fetch_req;
    logic             redir_pending;
    logic             misalign;

    modport master (
        output en, br_valid, br_target, exc_valid, fetch_ack,
        input  pc, pc_plus, fetch_req, redir_pending, misalign
    );

    modport slave (
        input  en, br_valid, br_target, exc_valid, fetch_ack,
        output pc, pc_plus, fetch_req, redir_pending, misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, exception/branch redirect arbitration, stalled-branch buffering.
// Optional PC_ALIGN_CHECK_EN: misaligned branch targets trap to EXC_VEC instead of being truncated.
module pc_gen #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(32'h0000_4180),
    parameter int unsigned      STEP        = 4,
    parameter int unsigned      BOOT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.slave   bus
);
    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [WIDTH-1:0] LOW_MASK  = WIDTH'(STEP - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_d;
    logic             misalign_q;
    logic             fetch_req_q;
    logic             redir_q;
    logic [WIDTH-1:0] tgt;
    logic             bad_tgt;

    assign tgt = bus.br_target & ~LOW_MASK;

`ifdef PC_ALIGN_CHECK_EN
    assign bad_tgt = |(bus.br_target & LOW_MASK);
`else
    assign bad_tgt = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            pend_q      <= '0;
            cnt_q       <= '0;
            misalign_q  <= 1'b0;
            fetch_req_q <= 1'b0;
            redir_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            misalign_q  <= trap_d;
            fetch_req_q <= (state_d != BOOT);
            redir_q     <= (state_d == PEND);
        end
    end

    // Next-state and redirect arbitration
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        trap_d  = 1'b0;
        case (state_q)
            BOOT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end
                if (bus.exc_valid) begin
                    pc_d = EXC_VEC;
                end
            end
            RUN: begin
                if (bus.exc_valid) begin
                    pc_d = EXC_VEC;
                end else if (bus.br_valid) begin
                    if (bad_tgt) begin
                        pc_d   = EXC_VEC;
                        trap_d = 1'b1;
                    end else if (bus.en) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = PEND;
                    end
                end else if (bus.en && bus.fetch_ack) begin
                    pc_d = bus.pc_plus;
                end
            end
            PEND: begin
                if (bus.exc_valid) begin
                    pc_d    = EXC_VEC;
                    pend_d  = '0;
                    state_d = RUN;
                end else if (bus.br_valid && bad_tgt) begin
                    pc_d    = EXC_VEC;
                    pend_d  = '0;
                    trap_d  = 1'b1;
                    state_d = RUN;
                end else if (bus.en) begin
                    // A branch arriving with the release beats the buffered one
                    pc_d    = bus.br_valid ? tgt : pend_q;
                    pend_d  = '0;
                    state_d = RUN;
                end else if (bus.br_valid) begin
                    pend_d = tgt;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_q + WIDTH'(STEP);
    assign bus.fetch_req     = fetch_req_q;
    assign bus.redir_pending = redir_q;
    assign bus.misalign      = misalign_q;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed literal checks plus randomized run against a behavioural model.
module tb_pc_gen;
    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_3000;
    localparam logic [31:0] EV    = 32'h0000_4180;
    localparam int unsigned STEP  = 4;
    localparam int unsigned BOOTC = 2;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_gen_if #(.WIDTH(WIDTH)) bus ();

    pc_gen #(
        .WIDTH(WIDTH), .RESET_VEC(RV), .EXC_VEC(EV), .STEP(STEP), .BOOT_CYCLES(BOOTC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: boot countdown, a pending flag and a target, updated on each rising edge
    logic [31:0] m_pc, m_ptgt;
    int          m_boot;
    bit          m_pend, m_mis, m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [31:0] t;
        bit          bad;
        t   = bus.br_target & ~32'(STEP - 1);
        bad = ALIGN && (bus.br_target % STEP != 0);
        if (rst) begin
            m_pc = RV; m_boot = BOOTC; m_pend = 0; m_ptgt = '0; m_mis = 0; m_valid = 1;
        end else if (m_valid) begin
            m_mis = 0;
            if (m_boot > 0) begin
                if (bus.exc_valid) m_pc = EV;
                m_boot = m_boot - 1;
            end else if (bus.exc_valid) begin
                m_pc = EV; m_pend = 0;
            end else if (bus.br_valid && bad) begin
                m_pc = EV; m_mis = 1; m_pend = 0;
            end else if (bus.en && (m_pend || bus.br_valid)) begin
                m_pc = bus.br_valid ? t : m_ptgt; m_pend = 0;
            end else if (bus.br_valid) begin
                m_ptgt = t; m_pend = 1;
            end else if (!m_pend && bus.en && bus.fetch_ack) begin
                m_pc = m_pc + STEP;
            end
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc", bus.pc, m_pc);
            chk("pc_plus", bus.pc_plus, m_pc + 32'(STEP));
            chk("fetch_req", 32'(bus.fetch_req), 32'(m_boot == 0));
            chk("redir_pending", 32'(bus.redir_pending), 32'(m_pend));
            chk("misalign", 32'(bus.misalign), 32'(m_mis));
        end
    end

    task automatic step(input logic r, input logic e, input logic b, input logic [31:0] t,
                        input logic x, input logic a);
        rst = r; bus.en = e; bus.br_valid = b; bus.br_target = t; bus.exc_valid = x; bus.fetch_ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] t;
        int          k;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_pc", bus.pc, 32'h0000_3000);
        chk("rst_fetch_req", 32'(bus.fetch_req), 0);
        chk("rst_redir", 32'(bus.redir_pending), 0);
        chk("rst_misalign", 32'(bus.misalign), 0);
        step(0, 1, 0, 0, 0, 1);
        chk("boot1_fetch_req", 32'(bus.fetch_req), 0);
        chk("boot1_pc", bus.pc, 32'h0000_3000);
        step(0, 0, 0, 0, 0, 0);
        chk("boot2_fetch_req", 32'(bus.fetch_req), 1);
        step(0, 1, 0, 0, 0, 1); chk("ack1", bus.pc, 32'h0000_3004);
        step(0, 1, 0, 0, 0, 1); chk("ack2", bus.pc, 32'h0000_3008);
        step(0, 1, 0, 0, 0, 1); chk("ack3", bus.pc, 32'h0000_300C);
        step(0, 1, 0, 0, 0, 1); chk("ack4", bus.pc, 32'h0000_3010);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1); chk("stall_hold", bus.pc, 32'h0000_3010);
        end
        step(0, 1, 0, 0, 0, 1); chk("stall_release", bus.pc, 32'h0000_3014);
        step(0, 0, 1, 32'h0000_3100, 0, 0);
        chk("pend1_pc", bus.pc, 32'h0000_3014);
        chk("pend1_flag", 32'(bus.redir_pending), 1);
        step(0, 0, 1, 32'h0000_3200, 0, 0);
        chk("pend2_flag", 32'(bus.redir_pending), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("pend_apply_pc", bus.pc, 32'h0000_3200);
        chk("pend_apply_flag", 32'(bus.redir_pending), 0);
        step(0, 1, 1, 32'h0000_3100, 1, 1);
        chk("exc_over_br_pc", bus.pc, 32'h0000_4180);
        step(0, 0, 1, 32'h0000_3100, 1, 0);
        chk("exc_over_stall_br_pc", bus.pc, 32'h0000_4180);
        chk("exc_over_stall_br_pend", 32'(bus.redir_pending), 0);
        step(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        chk("top_pc_plus", bus.pc_plus, 32'h0000_0000);
        step(0, 1, 0, 0, 0, 1);
        chk("wrap_pc", bus.pc, 32'h0000_0000);
        step(0, 1, 1, 32'h0000_3102, 0, 0);
        chk("misalign_pc", bus.pc, ALIGN ? 32'h0000_4180 : 32'h0000_3100);
        chk("misalign_pulse", 32'(bus.misalign), 32'(ALIGN));
        step(0, 0, 0, 0, 0, 0);
        chk("misalign_clear", 32'(bus.misalign), 0);
        step(0, 0, 1, 32'h0000_5000, 0, 0);
        chk("pend_exc_set", 32'(bus.redir_pending), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("pend_exc_pc", bus.pc, 32'h0000_4180);
        chk("pend_exc_flag", 32'(bus.redir_pending), 0);
        step(1, 1, 1, 32'h0000_3100, 0, 1);
        chk("rst_br_pc", bus.pc, 32'h0000_3000);
        chk("rst_br_fetch_req", 32'(bus.fetch_req), 0);
        step(0, 1, 1, 32'h0000_3100, 1, 1);
        chk("boot_exc_pc", bus.pc, 32'h0000_4180);
        chk("boot_exc_fetch_req", 32'(bus.fetch_req), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("boot_exc_done", 32'(bus.fetch_req), 1);
        chk("boot_exc_hold", bus.pc, 32'h0000_4180);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 7));
            case (k)
                0:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       t = $urandom;
                default: t = $urandom & 32'h0000_FFFC;
            endcase
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0,
                 t,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
        end
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
